// File: rtl/y_event_window_counter.sv
`default_nettype none
// ============================================================================
//  Module   : y_event_window_counter
//  Purpose  : Counts rising edges of the upstream Y level over fixed windows
//             of WIN_LEN clock cycles and hands each window's count to a
//             consumer over a valid/ready port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIN_LEN    window length in clk cycles (2..65535)
//    CNT_W      event-count width; the count saturates at 2**CNT_W-1
//  Ports
//    clk        in   1      clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    en         in   1      1 = run windows back to back, 0 = stop/abort
//    y_in       in   1      Y level, synchronous to clk
//    cnt_out    out  CNT_W  edge count of the completed window
//    cnt_valid  out  1      cnt_out holds an unconsumed result
//    cnt_ready  in   1      result accepted when cnt_valid & cnt_ready
//    busy       out  1      1 whenever the block is not idle
//    cnt_ovf    out  1      (Y_CNT_OVF_EN only) window count saturated
//  Build option
//    Y_CNT_OVF_EN  when defined, adds the cnt_ovf output and the internal
//                  overflow flag; otherwise saturation is silent.
// ============================================================================
module y_event_window_counter #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             y_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             busy
`ifdef Y_CNT_OVF_EN
    ,
    output logic             cnt_ovf
`endif
);

    localparam int                 c_WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic               r_y_prev;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0]   r_evt_cnt;
    logic [CNT_W-1:0]   r_cnt_out;
    logic               r_cnt_valid;

    state_t             w_state_nxt;
    logic [c_WIN_W-1:0] w_win_nxt;
    logic [CNT_W-1:0]   w_evt_nxt;
    logic [CNT_W-1:0]   w_out_nxt;
    logic               w_valid_nxt;

`ifdef Y_CNT_OVF_EN
    logic               r_ovf_flag;
    logic               r_cnt_ovf;
    logic               w_ovf_flag_nxt;
    logic               w_cnt_ovf_nxt;
    logic               w_ovf_flag_upd;
`endif

    logic               w_edge;
    logic               w_at_max;
    logic [CNT_W-1:0]   w_evt_upd;
    logic               w_accept;

    // Edge is taken against the previous cycle's sample, which is tracked in
    // every state so the first sample of a window sees the true prior level.
    assign w_edge    = y_in & ~r_y_prev;
    assign w_at_max  = (r_evt_cnt == c_CNT_MAX);
    assign w_evt_upd = (w_edge && !w_at_max) ? (r_evt_cnt + CNT_W'(1)) : r_evt_cnt;
    assign w_accept  = r_cnt_valid & cnt_ready;

`ifdef Y_CNT_OVF_EN
    // An edge arriving while the count is already pinned at max is lost.
    assign w_ovf_flag_upd = r_ovf_flag | (w_edge & w_at_max);
`endif

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_cnt;
        w_evt_nxt   = r_evt_cnt;
        w_out_nxt   = r_cnt_out;
        w_valid_nxt = r_cnt_valid;
`ifdef Y_CNT_OVF_EN
        w_ovf_flag_nxt = r_ovf_flag;
        w_cnt_ovf_nxt  = r_cnt_ovf;
`endif

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_RUN;
                    w_win_nxt   = '0;
                    w_evt_nxt   = '0;
`ifdef Y_CNT_OVF_EN
                    w_ovf_flag_nxt = 1'b0;
`endif
                end
            end

            S_RUN: begin
                if (!en) begin
                    // Abort: the partial count is simply abandoned; counters
                    // are cleared again on the next window entry.
                    w_state_nxt = S_IDLE;
                end else begin
                    w_evt_nxt = w_evt_upd;
`ifdef Y_CNT_OVF_EN
                    w_ovf_flag_nxt = w_ovf_flag_upd;
`endif
                    if (r_win_cnt == c_WIN_LAST) begin
                        // Last sample of the window: its edge is included.
                        w_out_nxt   = w_evt_upd;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_HOLD;
`ifdef Y_CNT_OVF_EN
                        w_cnt_ovf_nxt = w_ovf_flag_upd;
`endif
                    end else begin
                        w_win_nxt = r_win_cnt + c_WIN_W'(1);
                    end
                end
            end

            S_HOLD: begin
                // Edges are ignored here; the result stays put until taken.
                if (w_accept) begin
                    w_valid_nxt = 1'b0;
                    if (en) begin
                        w_state_nxt = S_RUN;
                        w_win_nxt   = '0;
                        w_evt_nxt   = '0;
`ifdef Y_CNT_OVF_EN
                        w_ovf_flag_nxt = 1'b0;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_y_prev    <= 1'b0;
            r_win_cnt   <= '0;
            r_evt_cnt   <= '0;
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
`ifdef Y_CNT_OVF_EN
            r_ovf_flag  <= 1'b0;
            r_cnt_ovf   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_y_prev    <= y_in;
            r_win_cnt   <= w_win_nxt;
            r_evt_cnt   <= w_evt_nxt;
            r_cnt_out   <= w_out_nxt;
            r_cnt_valid <= w_valid_nxt;
`ifdef Y_CNT_OVF_EN
            r_ovf_flag  <= w_ovf_flag_nxt;
            r_cnt_ovf   <= w_cnt_ovf_nxt;
`endif
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_valid = r_cnt_valid;
    assign busy      = (r_state != S_IDLE);
`ifdef Y_CNT_OVF_EN
    assign cnt_ovf   = r_cnt_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_y_event_window_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y_event_window_counter
//  Purpose  : Self-checking bench for y_event_window_counter. Two instances
//             (CNT_W=5 and CNT_W=2, WIN_LEN=16) share one stimulus stream.
//             A window-level reference model records each window's samples
//             and counts rising edges when the window closes; results go to
//             a queue that a negedge monitor pops on every handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_y_event_window_counter;

    localparam int WIN = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       y_in = 1'b0;
    logic       cnt_ready = 1'b0;
    logic [4:0] out_a;
    logic [1:0] out_b;
    logic       valid_a, valid_b, busy_a, busy_b;
`ifdef Y_CNT_OVF_EN
    logic       ovf_a, ovf_b;
`endif

    always #5 clk = ~clk;

    y_event_window_counter #(.WIN_LEN(WIN), .CNT_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .y_in(y_in),
        .cnt_out(out_a), .cnt_valid(valid_a), .cnt_ready(cnt_ready), .busy(busy_a)
`ifdef Y_CNT_OVF_EN
        , .cnt_ovf(ovf_a)
`endif
    );

    y_event_window_counter #(.WIN_LEN(WIN), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .y_in(y_in),
        .cnt_out(out_b), .cnt_valid(valid_b), .cnt_ready(cnt_ready), .busy(busy_b)
`ifdef Y_CNT_OVF_EN
        , .cnt_ovf(ovf_b)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    int exp_q[$];        // raw (unsaturated) edge count per finished window
    bit win_q[$];        // samples of the window in progress
    int m_state = M_IDLE;
    bit m_before = 1'b0; // level seen the cycle before the window's first sample
    bit exp_busy = 1'b0;
    bit exp_valid = 1'b0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic int window_edges();
        int n = 0;
        bit p = m_before;
        foreach (win_q[i]) begin
            if (win_q[i] && !p) n++;
            p = win_q[i];
        end
        return n;
    endfunction

    // One clock of stimulus. Inputs are applied 2 time units after the
    // rising edge; the model then predicts the state after the next edge.
    task automatic step(input bit e, input bit y, input bit r);
        @(posedge clk);
        #2;
        exp_busy  = (m_state != M_IDLE);
        exp_valid = (m_state == M_HOLD);
        en = e;
        y_in = y;
        cnt_ready = r;
        case (m_state)
            M_IDLE: if (e) begin
                m_state = M_RUN;
                m_before = y;
                win_q.delete();
            end
            M_RUN: if (!e) begin
                m_state = M_IDLE;
            end else begin
                win_q.push_back(y);
                if (win_q.size() == WIN) begin
                    exp_q.push_back(window_edges());
                    m_state = M_HOLD;
                end
            end
            default: if (r) begin
                if (e) begin
                    m_state = M_RUN;
                    m_before = y;
                    win_q.delete();
                end else begin
                    m_state = M_IDLE;
                end
            end
        endcase
    endtask

    // Monitor: samples on the falling edge, when the inputs that the next
    // rising edge will act on are already stable.
    always @(negedge clk) begin : mon
        int n;
        if (rst_n && mon_on) begin
            check("busy_w5", busy_a, exp_busy);
            check("busy_w2", busy_b, exp_busy);
            check("valid_w5", valid_a, exp_valid);
            check("valid_w2", valid_b, exp_valid);
            if (valid_a) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got %0d with no window pending at %0t", out_a, $time);
                end else begin
                    n = exp_q[0];
                    check("cnt_out_w5", out_a, sat(n, 31));
                    check("cnt_out_w2", out_b, sat(n, 3));
`ifdef Y_CNT_OVF_EN
                    check("cnt_ovf_w5", ovf_a, (n > 31) ? 1 : 0);
                    check("cnt_ovf_w2", ovf_b, (n > 3) ? 1 : 0);
`endif
                    if (cnt_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnt_out_w5"}, out_a, 0);
        check({tag, "_cnt_out_w2"}, out_b, 0);
        check({tag, "_valid_w5"}, valid_a, 0);
        check({tag, "_valid_w2"}, valid_b, 0);
        check({tag, "_busy_w5"}, busy_a, 0);
        check({tag, "_busy_w2"}, busy_b, 0);
`ifdef Y_CNT_OVF_EN
        check({tag, "_cnt_ovf_w2"}, ovf_b, 0);
`endif
    endtask

    initial begin
        // Power-on reset
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Alternating 0,1,... for one window: 8 edges (saturates at 3 in W2)
        step(1, 1, 1);
        for (int i = 0; i < WIN; i++) step(1, bit'(i % 2), 1);
        // Back-to-back window with y low throughout: 0
        step(1, 0, 1);
        for (int i = 0; i < WIN; i++) step(1, 0, 1);
        // y low before, then high for the whole window: 1
        step(1, 0, 1);
        for (int i = 0; i < WIN; i++) step(1, 1, 1);
        // Still high for the next window: 0
        step(1, 1, 1);
        for (int i = 0; i < WIN; i++) step(1, 1, 1);
        // Consumer stalls 5 cycles while y toggles, then accepts
        for (int i = 0; i < 5; i++) step(1, bit'(i % 2), 0);
        step(1, 0, 1);
        for (int i = 0; i < WIN; i++) step(1, bit'($urandom_range(0, 1)), 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Abort at window cycle 7, then a fresh full window
        step(1, 0, 1);
        for (int i = 0; i < 7; i++) step(1, bit'($urandom_range(0, 1)), 1);
        step(0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, bit'(i % 2), 1);
        step(1, 0, 1);
        for (int i = 0; i < WIN; i++) step(1, bit'($urandom_range(0, 1)), 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Reset asserted while a result is held
        step(1, 1, 0);
        for (int i = 0; i < WIN; i++) step(1, bit'(i % 2), 0);
        step(1, 0, 0);
        #1;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check_reset_outputs("midhold_reset");
        exp_q.delete();
        win_q.delete();
        m_state = M_IDLE;
        exp_busy = 1'b0;
        exp_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, bit'(i % 2), 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(bit'($urandom_range(0, 39) != 0),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) != 0));
        end

        // Drain: stop and accept anything pending
        for (int i = 0; i < 40; i++) step(0, 0, 1);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
